// File: rtl/serial_addsub16.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub16
// Description : Bit-serial WIDTH-bit adder/subtractor. A single full-adder
//               cell is reused over WIDTH cycles, LSB first. Subtraction is
//               computed as a + ~b + 1. Start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cb,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             sub_l;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             x;
    logic             y;
    logic             s;
    logic             c_next;

    // Handshake qualification and the shared full-adder cell
    always_comb begin
        accept = start && ((state == IDLE) || (state == DONE));
        last   = (cnt == CW'(WIDTH - 1));
        x      = a_sh[0];
        y      = b_sh[0] ^ sub_l;
        s      = x ^ y ^ carry;
        c_next = (x & y) | (x & carry) | (y & carry);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; start is ignored while shifting
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = accept ? SHIFT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one bit per cycle through the adder cell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sub_l  <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cb     <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            sub_l <= sub;
            // Carry-in of 1 supplies the +1 of the two's-complement negate
            carry <= sub;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            result <= {s, result[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= c_next;
            cnt    <= cnt + CW'(1);
            if (last) begin
                // Borrow is the inverted carry out when subtracting
                cb  <= sub_l ? ~c_next : c_next;
                // carry still holds the carry into the MSB at this point
                ovf <= carry ^ c_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub16.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub16
// Description : Self-checking bench for serial_addsub16; directed cases plus
//               random operands compared with an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cb;
    logic        ovf;

    int          n_vec;
    int          n_err;

    logic [15:0] exp_r;
    logic        exp_cb;
    logic        exp_ovf;

    serial_addsub16 #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cb     (cb),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    task automatic model(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(ta);
        ub = int'(tb_v);
        sa = int'($signed(ta));
        sb = int'($signed(tb_v));
        if (ts) begin
            ur     = ua - ub;
            sr     = sa - sb;
            exp_cb = (ua < ub);
        end else begin
            ur     = ua + ub;
            sr     = sa + sb;
            exp_cb = (ur > 65535);
        end
        exp_r   = ur[15:0];
        exp_ovf = (sr > 32767) || (sr < -32768);
    endtask

    // Present a request, clock it in, confirm busy; leaves start low
    task automatic launch(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts);
        model(ta, tb_v, ts);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        sub   = ts;
        @(posedge clk);
        #1;
        check("accept_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then check latency and the result flags
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        check({tag, "_latency"}, n, 16);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_result"}, {16'd0, result}, {16'd0, exp_r});
        check({tag, "_cb"}, {31'd0, cb}, {31'd0, exp_cb});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    endtask

    task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v, input logic ts);
        launch(ta, tb_v, ts);
        wait_done(tag);
        @(posedge clk);
        #1;
        check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("reset_outputs", {14'd0, busy, done, result}, 32'd0);
        check("reset_flags", {30'd0, cb, ovf}, 32'd0);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op("sub_nb",    16'h0005, 16'h0003, 1'b1);
        op("sub_b",     16'h0003, 16'h0005, 1'b1);
        op("sub_zero",  16'h0000, 16'h0000, 1'b1);
        op("sub_ovf",   16'h8000, 16'h0001, 1'b1);
        op("add_ovf",   16'h7FFF, 16'h0001, 1'b0);
        op("add_carry", 16'hFFFF, 16'h0001, 1'b0);
        op("add_plain", 16'h1234, 16'h4321, 1'b0);
        check("add_plain_const", {16'd0, result}, 32'h5555);

        // Start held high with operands changing during SHIFT: no restart
        launch(16'h0005, 16'h0003, 1'b1);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = 1'($urandom);
            @(posedge clk);
            #1;
        end
        // Back-to-back: the DONE cycle accepts the next request
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        check("hold_result", {16'd0, result}, 32'h0002);
        start = 1'b0;
        launch(16'h0010, 16'h0001, 1'b1);
        wait_done("b2b");
        check("b2b_const", {16'd0, result}, 32'h000F);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-operation
        launch(16'hA5A5, 16'h5A5B, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {14'd0, busy, done, result}, 32'd0);
        check("midrst_flags", {30'd0, cb, ovf}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("postrst_idle", {30'd0, busy, done}, 32'd0);
        op("postrst_op", 16'h0005, 16'h0003, 1'b1);

        for (int i = 0; i < 200; i++) begin
            op("rand", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_addsub16.md
Name: serial_addsub16

Overview:
- Bit-serial 16-bit adder/subtractor for the adder16 datapath.
- Reuses a single full-adder cell over WIDTH clock cycles, LSB first.
- Subtract mode is the inverse operation of the parallel adder: a + ~b + 1.
- Start/done handshake. Used where area matters more than latency; the result is checked against the parallel adder16.

Parameters:
- WIDTH, 16, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  1 = a - b, 0 = a + b; captured with operands
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- busy  output  1  operation in progress
- done  output  1  single-cycle pulse; result valid
- result  output  WIDTH  sum or difference
- cb  output  1  add: carry out; sub: borrow (1 when a < b unsigned)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, result=0, cb=0, ovf=0, bit counter=0, carry flop=0. Takes effect immediately, even mid-operation; the operation in progress is discarded.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Accept: start=1 at edge E0 while in IDLE or DONE.
  - Latch a, b, sub into shift registers.
  - Carry flop = sub (1 for subtract, 0 for add).
  - Counter=0; state -> SHIFT.
  - In SHIFT, start is ignored: no restart, no effect.
- Serial step, each edge in SHIFT:
  - Operand bit x = a_sh[0]; y = b_sh[0] XOR sub_latched.
  - s = x^y^c; c_next = majority(x,y,c).
  - s is shifted into result at the MSB end; a_sh and b_sh shift right.
  - Counter increments.
- Edges E1..E_WIDTH process bits 0..WIDTH-1. At E_WIDTH (E16 by default):
  - state -> DONE.
  - cb = sub ? ~c_out : c_out.
  - ovf = carry into MSB XOR carry out of MSB. The carry into the MSB is captured at bit WIDTH-1.
- Latency: done is high in the cycle after E16, i.e. 16 cycles after acceptance. The next edge, E17, returns to IDLE unless start=1, which is accepted back-to-back.
- result changes during SHIFT. result, cb and ovf are valid from done and held stable until the next accepted start. Their values during busy are undefined to consumers.
- sub, a and b may change freely after acceptance; only the latched copies are used.
- Width rule: result is modulo 2^WIDTH; no saturation.
- Counter width is clog2(WIDTH)+1. Terminal compare is counter == WIDTH-1 at the processing edge.

Test Plan:
- Subtract, no borrow: sub=1, a=0x0005, b=0x0003, start pulse at E0 -> busy=1 for 16 cycles; done one cycle later; result=0x0002, cb=0, ovf=0.
- Subtract with borrow: a=0x0003, b=0x0005, sub=1 -> result=0xFFFE, cb=1, ovf=0. Then a=0x0000, b=0x0000 -> result=0x0000, cb=0.
- Signed overflow, subtract: a=0x8000, b=0x0001, sub=1 -> result=0x7FFF, cb=0, ovf=1. Add case: a=0x7FFF, b=0x0001, sub=0 -> result=0x8000, cb=0, ovf=1.
- Add with carry: a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, cb=1, ovf=0. Also a=0x1234, b=0x4321 -> 0x5555, cb=0.
- Handshake:
  - Start held high and operands changed during SHIFT -> no restart; first result (0x0005-0x0003=0x0002) is delivered.
  - Start high in the DONE cycle with a=0x0010, b=0x0001, sub=1 -> accepted back-to-back; next done yields 0x000F.
- Reset mid-operation: rst_n low asynchronously at cycle 8 of SHIFT -> busy, done, result, cb, ovf = 0 immediately. After release, the block stays IDLE until start. A fresh operation 0x0005-0x0003 returns 0x0002.
- Every case is also cross-checked against the behavioural a±b over 200 random operand/sub pairs, with a correct flag reported.
